// File: rtl/toggle_req_debouncer.sv
// Push-button front end: 2-flop synchroniser, stability counter and a 4-state
// qualifier that emits one t_pulse per confirmed press for the downstream T-FF.
module toggle_req_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic en,
  output logic t_pulse,
  output logic btn_stable,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_pulse_q, t_pulse_d;
  logic             stable_q, stable_d;
  logic             busy_q, busy_d;

  // Next-state and next-output logic of the synchroniser and qualifier.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    t_pulse_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      CHK_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_HIGH;
          cnt_d     = CNT_ZERO;
          stable_d  = 1'b1;
          t_pulse_d = en;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      CHK_LOW: begin
        // A release is only qualified, never pulsed.
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_LOW;
          cnt_d    = CNT_ZERO;
          stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_LOW;
        cnt_d    = CNT_ZERO;
        stable_d = 1'b0;
      end
    endcase
    busy_d = (state_d == CHK_HIGH) || (state_d == CHK_LOW);
  end

  // State and registered outputs; reset abandons any qualification in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= CNT_ZERO;
      t_pulse_q <= 1'b0;
      stable_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_pulse_q <= t_pulse_d;
      stable_q  <= stable_d;
      busy_q    <= busy_d;
    end
  end

  assign t_pulse    = t_pulse_q;
  assign btn_stable = stable_q;
  assign busy       = busy_q;

endmodule
